// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit and its queue.
package if_fetch_unit_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int          QUEUE_DEPTH      = 2;
    localparam int          QPTR_W           = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int          QCNT_W           = $clog2(QUEUE_DEPTH + 1);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    // Tracks the single in-flight memory response; DROP means it belongs to a stale path.
    typedef enum logic [1:0] {
        FS_IDLE,
        FS_WAIT,
        FS_DROP
    } fetch_state_t;

    function automatic logic [31:0] pc_incr(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_fetch_unit_fetch_queue.sv
// Small FIFO of fetched {instruction, pc} pairs; head is presented combinationally.
module fetch_queue
    import if_fetch_unit_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic [31:0]       push_instr,
    input  logic [31:0]       push_pc,
    input  logic              pop,
    input  logic              flush,
    output logic [QCNT_W-1:0] count,
    output logic [31:0]       head_instr,
    output logic [31:0]       head_pc
);

    fetch_entry_t             slot_reg [QUEUE_DEPTH];
    logic [QPTR_W-1:0]        wr_ptr_reg, wr_ptr_next;
    logic [QPTR_W-1:0]        rd_ptr_reg, rd_ptr_next;
    logic [QCNT_W-1:0]        count_reg, count_next;
    logic [QUEUE_DEPTH-1:0]   slot_we;
    logic                     do_push, do_pop;
    fetch_entry_t             head_entry;

    // Flush wins over both push and pop; over/underflow attempts are ignored.
    assign do_push = push && !flush && (count_reg != QCNT_W'(QUEUE_DEPTH));
    assign do_pop  = pop  && !flush && (count_reg != '0);

    function automatic logic [QPTR_W-1:0] ptr_incr(input logic [QPTR_W-1:0] ptr);
        return (ptr == QPTR_W'(QUEUE_DEPTH - 1)) ? '0 : ptr + QPTR_W'(1);
    endfunction

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_next = ptr_incr(wr_ptr_reg);
            end
            if (do_pop) begin
                rd_ptr_next = ptr_incr(rd_ptr_reg);
            end
            count_next = count_reg + QCNT_W'(do_push) - QCNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    generate
        for (genvar gi = 0; gi < QUEUE_DEPTH; gi++) begin : g_slot
            assign slot_we[gi] = do_push && (wr_ptr_reg == QPTR_W'(gi));

            // Payload needs no reset: it is only observed while count is non-zero.
            always_ff @(posedge clk) begin
                if (slot_we[gi]) begin
                    slot_reg[gi] <= '{instr: push_instr, pc: push_pc};
                end
            end
        end
    endgenerate

    assign head_entry = slot_reg[rd_ptr_reg];
    assign head_instr = head_entry.instr;
    assign head_pc    = head_entry.pc;
    assign count      = count_reg;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch front end: PC generation, one-outstanding memory requests,
// redirect/flush handling with stale-response dropping, and a 2-deep output queue.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_instruction,
    output logic [31:0] if_pc_plus_4,
    output logic        if_valid
);

    localparam int EW = QCNT_W + 1;

    fetch_state_t      state_reg, state_next;
    logic              outstanding, drop;
    logic [31:0]       pc_reg, pc_next;
    logic [31:0]       req_pc_reg, req_pc_next;
    logic              rsp_arrive, q_push, q_pop, accept;
    logic [QCNT_W-1:0] q_count;
    logic [EW-1:0]     entries_next;
    logic [31:0]       head_instr, head_pc;

    assign rsp_arrive = imem_rvalid && outstanding;
    assign q_push     = rsp_arrive && !drop && !redirect;
    assign q_pop      = if_valid && !stall;

    assign entries_next = EW'(q_count) + EW'(q_push) - EW'(q_pop);

    // A new request must leave room for its own response once it returns.
    always_comb begin
        imem_req = reset_n && !redirect
                   && (!outstanding || imem_rvalid)
                   && (entries_next <= EW'(QUEUE_DEPTH - 1));
    end

    assign accept    = imem_req && imem_ready;
    assign imem_addr = pc_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= FS_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            FS_IDLE: begin
                if (accept) begin
                    state_next = FS_WAIT;
                end
            end
            FS_WAIT: begin
                if (rsp_arrive) begin
                    state_next = accept ? FS_WAIT : FS_IDLE;
                end else if (redirect) begin
                    state_next = FS_DROP;
                end
            end
            FS_DROP: begin
                if (rsp_arrive) begin
                    state_next = accept ? FS_WAIT : FS_IDLE;
                end
            end
            default: state_next = FS_IDLE;
        endcase
    end

    always_comb begin
        outstanding = 1'b0;
        drop        = 1'b0;
        case (state_reg)
            FS_WAIT: outstanding = 1'b1;
            FS_DROP: begin
                outstanding = 1'b1;
                drop        = 1'b1;
            end
            default: begin
                outstanding = 1'b0;
                drop        = 1'b0;
            end
        endcase
    end

    always_comb begin
        pc_next     = pc_reg;
        req_pc_next = req_pc_reg;
        if (redirect) begin
            pc_next = redirect_target;
        end else if (accept) begin
            pc_next = pc_incr(pc_reg);
        end
        if (accept) begin
            req_pc_next = pc_reg;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_reg     <= RESET_PC;
            req_pc_reg <= '0;
        end else begin
            pc_reg     <= pc_next;
            req_pc_reg <= req_pc_next;
        end
    end

    fetch_queue u_queue (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (q_push),
        .push_instr (imem_rdata),
        .push_pc    (req_pc_reg),
        .pop        (q_pop),
        .flush      (redirect),
        .count      (q_count),
        .head_instr (head_instr),
        .head_pc    (head_pc)
    );

    assign if_valid       = (q_count != '0);
    assign if_instruction = if_valid ? head_instr : NOP_INSTR;
    assign if_pc_plus_4   = if_valid ? pc_incr(head_pc) : 32'h0;

endmodule
